// File: rtl/bus_arbiter_if.sv
// Cache-side and bus-side handshake bundle for bus_arbiter.
// master = arbiter view; slave = caches/bus-pins view.
interface bus_arbiter_if #(
    parameter int DW = 64,
    parameter int TW = 13
);
    logic          p0_reqcyc,   p1_reqcyc;
    logic [DW-1:0] p0_req,      p1_req;
    logic [TW-1:0] p0_reqtag,   p1_reqtag;
    logic          p0_reqack,   p1_reqack;
    logic          p0_respcyc,  p1_respcyc;
    logic [DW-1:0] p0_resp,     p1_resp;
    logic [TW-1:0] p0_resptag,  p1_resptag;
    logic          p0_respack,  p1_respack;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;
    logic          arb_timeout;

    modport master (
        input  p0_reqcyc, p0_req, p0_reqtag, p0_respack,
        input  p1_reqcyc, p1_req, p1_reqtag, p1_respack,
        output p0_reqack, p0_respcyc, p0_resp, p0_resptag,
        output p1_reqack, p1_respcyc, p1_resp, p1_resptag,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack, arb_timeout,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        output p0_reqcyc, p0_req, p0_reqtag, p0_respack,
        output p1_reqcyc, p1_req, p1_reqtag, p1_respack,
        input  p0_reqack, p0_respcyc, p0_resp, p0_resptag,
        input  p1_reqack, p1_respcyc, p1_resp, p1_resptag,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack, arb_timeout,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one system bus between I-cache (port 0) and D-cache (port 1).
// Latency: 1 cycle IDLE->REQ arbitration; request/response paths combinational once granted.
// Backpressure: losers see reqack=0 until IDLE; bus acks pass straight through. Watchdog: BUS_ARB_WATCHDOG_EN.
module bus_arbiter #(
    parameter int BUS_DATA_WIDTH  = 64,
    parameter int BUS_TAG_WIDTH   = 13,
    parameter int BEATS_PER_LINE  = 8,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    bus_arbiter_if.master bif
);
    localparam int CNT_W = $clog2(BEATS_PER_LINE) + 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     grant_q, grant_d;
    logic                     last_q,  last_d;
    logic [CNT_W-1:0]         cnt_q,   cnt_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q,   tag_d;

    logic owner_reqcyc, owner_respack;
    logic resp_fwd, resp_done, wd_fire;

    assign owner_reqcyc  = grant_q ? bif.p1_reqcyc  : bif.p0_reqcyc;
    assign owner_respack = grant_q ? bif.p1_respack : bif.p0_respack;
    // Beats carrying a foreign tag belong to nobody: neither forwarded nor acked.
    assign resp_fwd  = (state_q == RESP) && bif.bus_respcyc && (bif.bus_resptag == tag_q);
    assign resp_done = resp_fwd && owner_respack;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

`ifdef BUS_ARB_WATCHDOG_EN
    logic [31:0] wd_q, wd_d;

    assign wd_fire = (state_q == RESP) && (wd_q == 32'(WATCHDOG_CYCLES));

    always_comb begin
        wd_d = '0;
        if (state_q == RESP && !resp_done && !wd_fire) begin
            wd_d = wd_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;

        bif.p0_reqack   = 1'b0;
        bif.p1_reqack   = 1'b0;
        bif.p0_respcyc  = 1'b0;
        bif.p1_respcyc  = 1'b0;
        bif.p0_resp     = bif.bus_resp;
        bif.p1_resp     = bif.bus_resp;
        bif.p0_resptag  = bif.bus_resptag;
        bif.p1_resptag  = bif.bus_resptag;
        bif.bus_reqcyc  = 1'b0;
        bif.bus_req     = '0;
        bif.bus_reqtag  = '0;
        bif.bus_respack = 1'b0;
        bif.arb_timeout = wd_fire;

        case (state_q)
            IDLE: begin
                if (bif.p0_reqcyc || bif.p1_reqcyc) begin
                    grant_d = (bif.p0_reqcyc && bif.p1_reqcyc) ? ~last_q : bif.p1_reqcyc;
                    tag_d   = grant_d ? bif.p1_reqtag : bif.p0_reqtag;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                bif.bus_reqcyc = owner_reqcyc;
                bif.bus_req    = grant_q ? bif.p1_req    : bif.p0_req;
                bif.bus_reqtag = grant_q ? bif.p1_reqtag : bif.p0_reqtag;
                bif.p0_reqack  = !grant_q && bif.bus_reqack;
                bif.p1_reqack  =  grant_q && bif.bus_reqack;
                if (owner_reqcyc && bif.bus_reqack) begin
                    if (tag_q[BUS_TAG_WIDTH-1]) begin
                        last_d  = grant_q;
                        cnt_d   = '0;
                        state_d = RESP;
                    end else if (cnt_q == CNT_W'(BEATS_PER_LINE)) begin
                        // address beat plus a full line of data has gone out
                        last_d  = grant_q;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                bif.p0_respcyc  = !grant_q && resp_fwd;
                bif.p1_respcyc  =  grant_q && resp_fwd;
                bif.bus_respack = resp_done;
                if (resp_done) begin
                    if (cnt_q == CNT_W'(BEATS_PER_LINE - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (wd_fire) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // While reset is held the arbiter presents a quiet bus regardless of state.
        if (!reset) begin
            bif.p0_reqack   = 1'b0;
            bif.p1_reqack   = 1'b0;
            bif.p0_respcyc  = 1'b0;
            bif.p1_respcyc  = 1'b0;
            bif.bus_reqcyc  = 1'b0;
            bif.bus_req     = '0;
            bif.bus_reqtag  = '0;
            bif.bus_respack = 1'b0;
            bif.arb_timeout = 1'b0;
        end
    end
endmodule
